// File: rtl/plus_acc_pipe.sv
// Two-stage pipelined adder/accumulator with valid/ready handshakes on both sides.
// Optional saturating accumulator with sticky overflow flag: define PLUS_ACC_SAT_EN.
module plus_acc_pipe #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_mode,
    input  logic              in_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum_out,
    output logic              acc_ovf
);

    localparam int unsigned SUM_W = DATA_W + 1;

    logic              s1_valid;
    logic [SUM_W-1:0]  s1_sum;
    logic              s1_mode;
    logic              s1_clr;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic [ACC_W-1:0]  res_nxt;
    logic [ACC_W-1:0]  s_ext;
    logic [ACC_W-1:0]  base;

    logic              s2_load;
    logic              s1_adv;

    // Backpressure: each stage moves only when the one after it can take its contents.
    assign s2_load  = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_load;
    assign in_ready = s1_adv;

    // Stage 1: capture the full-width operand sum and transaction controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_mode  <= 1'b0;
            s1_clr   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum  <= SUM_W'(in_a) + SUM_W'(in_b);
                s1_mode <= in_mode;
                s1_clr  <= in_clr;
            end
        end
    end

`ifdef PLUS_ACC_SAT_EN
    logic [ACC_W:0] sum_wide;
    logic           ovf_nxt;
    logic           ovf_q;

    // Stage 2 datapath: clear precedes add; carry out of the accumulator saturates.
    always_comb begin
        s_ext    = ACC_W'(s1_sum);
        base     = s1_clr ? '0 : acc;
        sum_wide = {1'b0, base} + {1'b0, s_ext};
        acc_nxt  = base;
        res_nxt  = s_ext;
        ovf_nxt  = s1_clr ? 1'b0 : ovf_q;
        if (s1_mode) begin
            if (sum_wide[ACC_W]) begin
                acc_nxt = '1;
                ovf_nxt = 1'b1;
            end else begin
                acc_nxt = sum_wide[ACC_W-1:0];
            end
            res_nxt = acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (s2_load && s1_valid) begin
            ovf_q <= ovf_nxt;
        end
    end

    assign acc_ovf = ovf_q;
`else
    // Stage 2 datapath: clear precedes add; accumulator wraps modulo 2^ACC_W.
    always_comb begin
        s_ext   = ACC_W'(s1_sum);
        base    = s1_clr ? '0 : acc;
        acc_nxt = base;
        res_nxt = s_ext;
        if (s1_mode) begin
            acc_nxt = base + s_ext;
            res_nxt = acc_nxt;
        end
    end

    assign acc_ovf = 1'b0;
`endif

    // Stage 2: result register and accumulator, updated only when the stage loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum_out   <= '0;
            acc       <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum_out <= res_nxt;
                acc     <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_plus_acc_pipe.sv
// Directed bench for plus_acc_pipe (DATA_W=11, ACC_W=16): streaming vector table
// plus hand-written stall, overflow and mid-stream reset sequences.
module tb_plus_acc_pipe;

    localparam int unsigned DATA_W = 11;
    localparam int unsigned ACC_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_mode;
    logic              in_clr;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  sum_out;
    logic              acc_ovf;

    plus_acc_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .in_clr    (in_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .acc_ovf   (acc_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              mode;
        logic              clr;
        logic [ACC_W-1:0]  exp_sum;
        logic              exp_ovf;
    } vec_t;

    vec_t vecs[$];
    int checks   = 0;
    int failures = 0;

`ifdef PLUS_ACC_SAT_EN
    localparam logic [ACC_W-1:0] OVF_SUM = 16'd65535;
    localparam logic             OVF_FLG = 1'b1;
`else
    localparam logic [ACC_W-1:0] OVF_SUM = 16'd4062;
    localparam logic             OVF_FLG = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input bit mode, input bit clr,
                                input int exp_sum, input bit exp_ovf);
        vec_t v;
        v.a       = DATA_W'(a);
        v.b       = DATA_W'(b);
        v.mode    = mode;
        v.clr     = clr;
        v.exp_sum = ACC_W'(exp_sum);
        v.exp_ovf = exp_ovf;
        return v;
    endfunction

    // One transaction with out_ready=1; waits a bounded number of cycles for its result.
    task automatic run_one(input int a, input int b, input bit mode, input bit clr,
                           input int exp_sum, input string name);
        int n;
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = DATA_W'(a);
        in_b     = DATA_W'(b);
        in_mode  = mode;
        in_clr   = clr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got out_valid 0 expected 1", name);
        end else begin
            check(name, 32'(sum_out), 32'(exp_sum));
        end
    endtask

    initial begin
        int n;
        int acc_cnt;
        int got;

        // Mode0 sums, accumulate/clear interplay, then overflow run.
        vecs.push_back(mk(30, 27, 0, 0, 57, 0));
        vecs.push_back(mk(1000, 900, 0, 0, 1900, 0));
        vecs.push_back(mk(2047, 2047, 0, 0, 4094, 0));
        vecs.push_back(mk(30, 27, 1, 1, 57, 0));
        vecs.push_back(mk(1000, 900, 1, 0, 1957, 0));
        vecs.push_back(mk(5, 5, 0, 0, 10, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1957, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(7, 0, 1, 0, 7, 0));
        vecs.push_back(mk(1, 2, 1, 1, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0));
        for (int k = 1; k <= 16; k++) vecs.push_back(mk(2047, 2047, 1, 0, k * 4094, 0));
        vecs.push_back(mk(2047, 2047, 1, 0, int'(OVF_SUM), OVF_FLG));
        vecs.push_back(mk(0, 0, 1, 0, int'(OVF_SUM), OVF_FLG));
        vecs.push_back(mk(1, 1, 0, 1, 2, 0));

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = 1'b0;
        in_clr    = 1'b0;
        out_ready = 1'b1;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum_out", 32'(sum_out), 32'd0);
        check("rst_acc_ovf", 32'(acc_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Streaming table: one transaction per cycle, result checked 2 edges later.
        n = vecs.size();
        for (int k = 0; k <= n; k++) begin
            if (k < n) begin
                in_valid = 1'b1;
                in_a     = vecs[k].a;
                in_b     = vecs[k].b;
                in_mode  = vecs[k].mode;
                in_clr   = vecs[k].clr;
                check($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (k == 0) begin
                check("vec0_latency", 32'(out_valid), 32'd0);
            end else begin
                check($sformatf("vec%0d_out_valid", k - 1), 32'(out_valid), 32'd1);
                check($sformatf("vec%0d_sum", k - 1), 32'(sum_out), 32'(vecs[k-1].exp_sum));
                check($sformatf("vec%0d_ovf", k - 1), 32'(acc_ovf), 32'(vecs[k-1].exp_ovf));
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // Stall: downstream blocked for 5 cycles while 1,2,3 are offered.
        out_ready = 1'b0;
        in_b      = '0;
        in_mode   = 1'b0;
        in_clr    = 1'b0;
        acc_cnt   = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_a     = DATA_W'(acc_cnt + 1);
            if (in_ready) acc_cnt++;
            @(posedge clk); #1;
            if (out_valid) check($sformatf("stall_hold%0d", c), 32'(sum_out), 32'd1);
        end
        check("stall_accepted", 32'(acc_cnt), 32'd2);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);

        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            in_valid = (acc_cnt < 3);
            in_a     = DATA_W'(acc_cnt + 1);
            if (in_valid && in_ready) acc_cnt++;
            if (out_valid) begin
                check($sformatf("stall_out%0d", got), 32'(sum_out), 32'(got + 1));
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("stall_drained", 32'(got), 32'd3);
        @(posedge clk); #1;
        check("stall_no_dup", 32'(out_valid), 32'd0);

        // Mid-stream reset with two transactions in flight.
        in_valid = 1'b1;
        in_a     = DATA_W'(100);
        in_b     = '0;
        in_mode  = 1'b1;
        in_clr   = 1'b0;
        @(posedge clk); #1;
        in_a    = DATA_W'(5);
        in_b    = DATA_W'(5);
        in_mode = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("inflight_out_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum_out", 32'(sum_out), 32'd0);
        check("midrst_acc_ovf", 32'(acc_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("midrst_no_stale%0d", c), 32'(out_valid), 32'd0);
        end
        run_one(30, 27, 1, 0, 57, "post_rst_acc");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
